// File: rtl/booth_r8_pkg.sv
// Shared types and helpers for the radix-8 Booth sequential multiplier.
package booth_r8_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      ITER,
      DONE
   } state_t;

   // Magnitude field of the digit select (sel[2:0]); sel[3] carries the sign.
   localparam logic [2:0] SEL_ZERO = 3'd0;
   localparam logic [2:0] SEL_1A   = 3'd1;
   localparam logic [2:0] SEL_2A   = 3'd2;
   localparam logic [2:0] SEL_3A   = 3'd3;
   localparam logic [2:0] SEL_4A   = 3'd4;

   // Number of radix-8 digits needed for a width-bit multiplier (with b[-1]
   // and room for a sign/zero extension bit).
   function automatic int unsigned n_digits(input int unsigned width);
      return (width + 2 + 2) / 3;
   endfunction

   // Window is {b[3i+2], b[3i+1], b[3i], b[3i-1]};
   // digit = -4*w[3] + 2*w[2] + w[1] + w[0].
   function automatic logic [3:0] booth_r8_encode(input logic [3:0] win);
      logic [3:0] sel;
      sel = {1'b0, SEL_ZERO};
      case (win)
         4'b0000, 4'b1111: sel = {1'b0, SEL_ZERO};
         4'b0001, 4'b0010: sel = {1'b0, SEL_1A};
         4'b0011, 4'b0100: sel = {1'b0, SEL_2A};
         4'b0101, 4'b0110: sel = {1'b0, SEL_3A};
         4'b0111:          sel = {1'b0, SEL_4A};
         4'b1000:          sel = {1'b1, SEL_4A};
         4'b1001, 4'b1010: sel = {1'b1, SEL_3A};
         4'b1011, 4'b1100: sel = {1'b1, SEL_2A};
         4'b1101, 4'b1110: sel = {1'b1, SEL_1A};
         default:          sel = {1'b0, SEL_ZERO};
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_r8_pp_gen.sv
// Radix-8 Booth partial-product generator: selects 0/A/2A/3A/4A and applies
// the digit sign by two's-complement negation.
module booth_r8_pp_gen
   import booth_r8_pkg::*;
#(
   parameter int unsigned A_WIDTH = 16
) (
   input  logic [A_WIDTH:0]   i_a,
   input  logic [A_WIDTH+2:0] i_a3,
   input  logic [3:0]         i_sel,
   output logic [A_WIDTH+3:0] o_pp
);

   logic [A_WIDTH+3:0] w_mag;

   // Pick the signed magnitude multiple, then negate for negative digits.
   always_comb begin
      w_mag = '0;
      case (i_sel[2:0])
         SEL_1A:  w_mag = {{3{i_a[A_WIDTH]}}, i_a};
         SEL_2A:  w_mag = {{2{i_a[A_WIDTH]}}, i_a, 1'b0};
         SEL_3A:  w_mag = {i_a3[A_WIDTH+2], i_a3};
         SEL_4A:  w_mag = {i_a[A_WIDTH], i_a, 2'b00};
         default: w_mag = '0;
      endcase
      o_pp = i_sel[3] ? ('0 - w_mag) : w_mag;
   end

endmodule

// File: rtl/booth_r8_seq_mult.sv
// Iterative radix-8 Booth multiplier, one digit per cycle, signed/unsigned
// selectable per transaction, valid/ready on both sides.
module booth_r8_seq_mult
   import booth_r8_pkg::*;
#(
   parameter  int unsigned A_WIDTH = 16,
   parameter  int unsigned B_WIDTH = 16,
   localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] in_a,
   input  logic [B_WIDTH-1:0] in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] out_p
);

   localparam int unsigned N_DIG = n_digits(B_WIDTH);
   localparam int unsigned BX_W  = 3 * N_DIG;
   localparam int unsigned CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [A_WIDTH:0]   r_a;
   logic [BX_W:0]      r_b;      // bit 0 is the implicit b[-1]
   logic [A_WIDTH+2:0] r_a3;
   logic [P_WIDTH-1:0] r_p;
   logic [P_WIDTH-1:0] r_out_p;
   logic [CNT_W-1:0]   r_i;

   logic               w_accept;
   logic               w_last;
   logic               w_a_ext_msb;
   logic               w_b_ext_msb;
   logic [A_WIDTH+2:0] w_a3;
   logic [3:0]         w_sel;
   logic [A_WIDTH+3:0] w_pp;
   logic [P_WIDTH-1:0] w_pp_sh;
   logic [P_WIDTH-1:0] w_p_sum;

   assign w_accept    = (r_state == IDLE) && in_valid;
   assign w_last      = (r_i == LAST_DIG);
   assign w_a_ext_msb = in_signed & in_a[A_WIDTH-1];
   assign w_b_ext_msb = in_signed & in_b[B_WIDTH-1];
   assign w_a3        = {{2{r_a[A_WIDTH]}}, r_a} + {r_a[A_WIDTH], r_a, 1'b0};

   // r_b is shifted right 3 bits per digit, so the current window is always
   // the low four bits; the product side keeps the explicit << 3i weighting.
   assign w_sel   = booth_r8_encode(r_b[3:0]);
   assign w_pp_sh = P_WIDTH'($signed(w_pp)) << (32'd3 * 32'(r_i));
   assign w_p_sum = r_p + w_pp_sh;
   assign out_p   = r_out_p;

   booth_r8_pp_gen #(
      .A_WIDTH (A_WIDTH)
   ) u_pp_gen (
      .i_a   (r_a),
      .i_a3  (r_a3),
      .i_sel (w_sel),
      .o_pp  (w_pp)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; no new operand is taken while a result is pending.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = PRE;
         PRE:     w_state_nxt = ITER;
         ITER:    if (w_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture, 3A precompute, digit accumulation, result hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_a3    <= '0;
         r_p     <= '0;
         r_i     <= '0;
         r_out_p <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a <= {w_a_ext_msb, in_a};
                  r_b <= {{(BX_W - B_WIDTH){w_b_ext_msb}}, in_b, 1'b0};
               end
            end
            PRE: begin
               r_a3 <= w_a3;
               r_p  <= '0;
               r_i  <= '0;
            end
            ITER: begin
               r_p <= w_p_sum;
               r_b <= r_b >> 3;
               r_i <= r_i + CNT_W'(1);
               if (w_last) r_out_p <= w_p_sum;
            end
            default: ;
         endcase
      end
   end

endmodule
